// File: rtl/seq_stream_checker.sv
// ---------------------------------------------------------------------------
// seq_stream_checker
//
// Watches the output of the repeating code counter (0,2,5,8,11,14,0,...),
// locks onto the sequence once a 0 is seen, and from then on flags every
// sample that breaks the sequence. Completed laps and mismatches are counted
// in saturating counters that software can clear.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   in_valid   in_code is meaningful this cycle
//   in_code    4-bit code from the sequence counter
//   clr        synchronous clear of lap_count / err_count
//   locked     checker is tracking the sequence
//   exp_code   code expected on the next valid sample (0 while hunting)
//   err        one-cycle pulse, mismatch detected while locked
//   lap_done   one-cycle pulse, code 14 accepted while locked
//   lap_count  completed laps, saturating at all-ones
//   err_count  mismatches, saturating at all-ones
//
// Every output comes straight from a flop, so there is exactly one cycle of
// latency and no combinational input-to-output path.
// ---------------------------------------------------------------------------
module seq_stream_checker #(
    parameter int LAP_W = 8,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [3:0]       in_code,
    input  logic             clr,
    output logic             locked,
    output logic [3:0]       exp_code,
    output logic             err,
    output logic             lap_done,
    output logic [LAP_W-1:0] lap_count,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         exp_code_q, exp_code_d;
    logic               err_q, err_d;
    logic               lap_done_q, lap_done_d;
    logic [LAP_W-1:0]   lap_count_q, lap_count_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;

    logic               code_match;

    // Successor in the code table; illegal codes never reach here as an
    // expected value, so they simply fall back to the start of the lap.
    function automatic logic [3:0] next_code(input logic [3:0] code);
        case (code)
            4'd0:    next_code = 4'd2;
            4'd2:    next_code = 4'd5;
            4'd5:    next_code = 4'd8;
            4'd8:    next_code = 4'd11;
            4'd11:   next_code = 4'd14;
            default: next_code = 4'd0;
        endcase
    endfunction

    assign code_match = (in_code == exp_code_q);

    // State register and all output flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= HUNT;
            exp_code_q  <= 4'd0;
            err_q       <= 1'b0;
            lap_done_q  <= 1'b0;
            lap_count_q <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            exp_code_q  <= exp_code_d;
            err_q       <= err_d;
            lap_done_q  <= lap_done_d;
            lap_count_q <= lap_count_d;
            err_count_q <= err_count_d;
        end
    end

    // Next-state logic. A mismatch on code 0 is treated as the start of a
    // new lap, so the checker stays locked and only drops out otherwise.
    always_comb begin
        state_d = state_q;
        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    if (in_code == 4'd0) begin
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (!code_match && (in_code != 4'd0)) begin
                        state_d = HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Output logic: expected code, pulses and saturating counters. clr is
    // applied last so it wins over an increment on the same edge.
    always_comb begin
        exp_code_d  = exp_code_q;
        err_d       = 1'b0;
        lap_done_d  = 1'b0;
        lap_count_d = lap_count_q;
        err_count_d = err_count_q;

        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    if (in_code == 4'd0) begin
                        exp_code_d = 4'd2;
                    end else begin
                        exp_code_d = 4'd0;
                    end
                end
                LOCKED: begin
                    if (code_match) begin
                        exp_code_d = next_code(in_code);
                        if (in_code == 4'd14) begin
                            lap_done_d = 1'b1;
                            if (lap_count_q != '1) begin
                                lap_count_d = lap_count_q + 1'b1;
                            end
                        end
                    end else begin
                        err_d = 1'b1;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + 1'b1;
                        end
                        exp_code_d = (in_code == 4'd0) ? 4'd2 : 4'd0;
                    end
                end
                default: exp_code_d = 4'd0;
            endcase
        end

        if (clr) begin
            lap_count_d = '0;
            err_count_d = '0;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign exp_code  = exp_code_q;
    assign err       = err_q;
    assign lap_done  = lap_done_q;
    assign lap_count = lap_count_q;
    assign err_count = err_count_q;

endmodule

// File: doc/seq_stream_checker.md
Name: seq_stream_checker

Overview:
- Downstream consumer of the 4-bit repeating code counter (0 -> 2 -> 5 -> 8 -> 11 -> 14 -> 0).
- Samples each valid code and locks onto the expected sequence.
- Flags any deviation, counts completed laps and errors, and reports lock status for system monitoring and debug.

Parameters:
LAP_W, 8, width of saturating lap counter
ERR_W, 8, width of saturating error counter

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  in_code is meaningful this cycle
in_code  input  4  code from sequence counter
clr  input  1  synchronous clear of lap_count/err_count
locked  output  1  checker is tracking the sequence
exp_code  output  4  code expected on next valid sample (0 while hunting)
err  output  1  one-cycle pulse: mismatch detected
lap_done  output  1  one-cycle pulse: code 14 accepted in lock, lap complete
lap_count  output  LAP_W  completed laps, saturating at all-ones
err_count  output  ERR_W  mismatches, saturating at all-ones

Behaviour:
- Reset and clock
  - Only clk is used. reset low asynchronously forces: state=HUNT, locked=0, exp_code=0, err=0, lap_done=0, lap_count=0, err_count=0.
  - Deassertion is sampled on the next rising clk.
  - Reset mid-lap discards all progress; the checker re-hunts from scratch.
- Sequence table
  - Index 0..5 maps to codes 0, 2, 5, 8, 11, 14.
  - Successor of index 5 is index 0.
  - Codes 1, 3, 4, 6, 7, 9, 10, 12, 13, 15 are never legal.
- Timing
  - All outputs are registered.
  - An input sampled at edge N is reflected in the outputs after edge N, i.e. one-cycle latency.
- in_valid=0 in any state: state, exp_code and counters hold; err=0 and lap_done=0.
- State HUNT (locked=0, exp_code=0):
  - in_valid and in_code==0: go to LOCKED with exp_code=2. No pulses.
  - in_valid and any other code: stay in HUNT. No err; mismatches while hunting are not errors.
- State LOCKED (locked=1):
  - in_valid and in_code==exp_code: advance exp_code to the successor.
    - If in_code==14, pulse lap_done and increment lap_count; exp_code becomes 0.
  - in_valid and in_code!=exp_code: pulse err and increment err_count.
    - If in_code==0: stay in LOCKED and resynchronise, exp_code=2.
    - Otherwise: go to HUNT with exp_code=0 and locked=0.
  - The first lap after lock counts, since 0 started it.
- Counters
  - Unsigned increment by 1; hold at all-ones, with no wrap.
  - err and lap_done pulses still fire when the counter is saturated.
- clr=1
  - lap_count and err_count go to 0 on that edge.
  - clr has priority over a simultaneous increment: the counter goes to 0, not 1.
  - The pulse outputs and the state machine are unaffected by clr.
- err and lap_done are mutually exclusive and never both high.
- No combinational path from any input to any output.

Test Plan:
- Reset, then feed in_valid=1 with codes 0, 2, 5, 8, 11, 14, 0 -> locked=1 after the first edge; lap_done pulses exactly once, one cycle after 14 is sampled; lap_count=1, err_count=0; exp_code ends at 2.
- Hunt filtering: feed 5, 8, 3, 0, 2 -> locked stays 0 and err never pulses until 0 is sampled; then locked=1, and exp_code=5 after 2 is sampled.
- Mismatch handling:
  - Locked, expecting 8, feed 9 -> err pulse, err_count=1, locked=0, exp_code=0.
  - Separately, locked, expecting 11, feed 0 -> err pulse, locked stays 1, exp_code=2.
- Gapped valid: sequence 0, 2, 5 with in_valid low for 3 cycles between each sample -> no err, exp_code holds during the gaps, locked remains 1.
- Saturation and clear:
  - With LAP_W=2, run 5 laps -> lap_count=3 and lap_done pulses 5 times.
  - Assert clr on the same cycle as the sample of 14 -> lap_count=0 and lap_done still pulses.
- Async reset mid-lap: drop reset between clock edges while exp_code=8 -> all outputs 0 immediately without a clock edge; after release, feed 8 -> no lock and no err.
